// File: rtl/mc_nvram_backup_if.sv
// Host image-transfer (ioctl) and SDRAM port signals of the cart NVRAM backup engine.
// slave is the engine's view; master is the host/memory side that drives it.
interface mc_nvram_backup_if;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic [12:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [22:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;

    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd, ioctl_addr, ioctl_din,
        input  mem_din, mem_ack,
        output ioctl_dout, ioctl_wait, mem_addr, mem_dout, mem_we, mem_req
    );

    modport master (
        output ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd, ioctl_addr, ioctl_din,
        output mem_din, mem_ack,
        input  ioctl_dout, ioctl_wait, mem_addr, mem_dout, mem_we, mem_req
    );
endinterface

// File: rtl/mc_nvram_backup.sv
// Moves the 8 KB cart NVRAM image between the host ioctl port and SDRAM,
// unmangling file offsets into the cart address space, with an ack timeout.
module mc_nvram_backup #(
    parameter logic [22:0] BASE    = 23'h400000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    mc_nvram_backup_if.slave  bus,
    output logic              busy,
    output logic              error
);
    typedef enum logic [1:0] {S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_HOLD} state_t;

    state_t      r_state;
    logic [22:0] r_mem_addr;
    logic [7:0]  r_mem_dout;
    logic        r_mem_we;
    logic        r_mem_req;
    logic [7:0]  r_ioctl_dout;
    logic        r_busy;
    logic        r_error;
    logic [7:0]  r_cnt;
    logic        r_dl_q;
    logic        r_ul_q;

    logic        w_f_lo;
    logic        w_f_hi;
    logic        w_mapped;
    logic [22:0] w_addr;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_flag_rise;
    logic        w_do_wr;
    logic        w_do_rd;

    // Offsets 0x0400-0x0FFF sit at BASE+f; 0x1800-0x1FFF land in the VIC 0x9800 window.
    assign w_f_lo   = ~bus.ioctl_addr[12] & (bus.ioctl_addr[11:10] != 2'b00);
    assign w_f_hi   = bus.ioctl_addr[12] & bus.ioctl_addr[11];
    assign w_mapped = w_f_lo | w_f_hi;
    assign w_addr   = BASE + 23'(bus.ioctl_addr) + (w_f_hi ? 23'h008000 : 23'h000000);

    assign w_cnt_inc   = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_timeout   = 32'(w_cnt_inc) >= TIMEOUT;
    assign w_flag_rise = (bus.ioctl_download & ~r_dl_q) | (bus.ioctl_upload & ~r_ul_q);
    assign w_do_wr     = bus.ioctl_download & bus.ioctl_wr;
    assign w_do_rd     = bus.ioctl_upload & bus.ioctl_rd & ~bus.ioctl_download;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mem_addr   <= '0;
            r_mem_dout   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_ioctl_dout <= 8'hFF;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
            r_cnt        <= '0;
            r_dl_q       <= 1'b0;
            r_ul_q       <= 1'b0;
        end else begin
            r_dl_q <= bus.ioctl_download;
            r_ul_q <= bus.ioctl_upload;
            if (w_flag_rise) r_error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_do_wr) begin
                        if (w_mapped) begin
                            r_state    <= S_WR_REQ;
                            r_mem_addr <= w_addr;
                            r_mem_dout <= bus.ioctl_din;
                            r_mem_we   <= 1'b1;
                            r_mem_req  <= 1'b1;
                            r_busy     <= 1'b1;
                            r_cnt      <= '0;
                        end
                    end else if (w_do_rd) begin
                        if (w_mapped) begin
                            r_state    <= S_RD_REQ;
                            r_mem_addr <= w_addr;
                            r_mem_we   <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_busy     <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            r_ioctl_dout <= 8'hFF;
                        end
                    end
                end
                S_WR_REQ, S_RD_REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_state == S_RD_REQ) begin
                            r_ioctl_dout <= bus.mem_din;
                            r_state      <= S_RD_HOLD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Abandon the access; ioctl_dout keeps its previous byte.
                        if (w_timeout) begin
                            r_mem_req <= 1'b0;
                            r_busy    <= 1'b0;
                            r_error   <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_RD_HOLD: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_dout   = r_mem_dout;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_req    = r_mem_req;
    assign bus.ioctl_dout = r_ioctl_dout;
    assign bus.ioctl_wait = r_busy;
    assign busy           = r_busy;
    assign error          = r_error;
endmodule

// File: tb/tb_mc_nvram_backup.sv
// Directed bench for mc_nvram_backup: load/save mapping, wait timing, timeout,
// priority and reset-abort cases against hand-computed values.
module tb_mc_nvram_backup;
    logic clk;
    logic reset;
    logic busy;
    logic error;
    int   errors;
    int   checks;
    int   n;

    mc_nvram_backup_if bus();

    mc_nvram_backup dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_wr(input logic [12:0] f, input logic [7:0] d);
        bus.ioctl_addr = f;
        bus.ioctl_din  = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic strobe_rd(input logic [12:0] f);
        bus.ioctl_addr = f;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd   = 1'b0;
    endtask

    task automatic pulse_ack(input logic [7:0] d);
        bus.mem_din = d;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(bus.mem_req),    32'h0);
        check({tag, "_we"},    32'(bus.mem_we),     32'h0);
        check({tag, "_wait"},  32'(bus.ioctl_wait), 32'h0);
        check({tag, "_busy"},  32'(busy),           32'h0);
        check({tag, "_err"},   32'(error),          32'h0);
        check({tag, "_dout"},  32'(bus.ioctl_dout), 32'hFF);
        check({tag, "_maddr"}, 32'(bus.mem_addr),   32'h0);
        check({tag, "_mdout"}, 32'(bus.mem_dout),   32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_rd       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_din      = '0;
        bus.mem_din        = '0;
        bus.mem_ack        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_values("rst");

        // Mapped load at 0x0400, ack arriving after three request cycles.
        bus.ioctl_download = 1'b1;
        tick();
        strobe_wr(13'h0400, 8'h5A);
        check("wr0_req",  32'(bus.mem_req),  32'h1);
        check("wr0_we",   32'(bus.mem_we),   32'h1);
        check("wr0_addr", 32'(bus.mem_addr), 32'h400400);
        check("wr0_dout", 32'(bus.mem_dout), 32'h5A);
        n = bus.ioctl_wait ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.ioctl_wait) n++;
        end
        check("wr0_hold_addr", 32'(bus.mem_addr), 32'h400400);
        check("wr0_hold_req",  32'(bus.mem_req),  32'h1);
        pulse_ack(8'h00);
        if (bus.ioctl_wait) n++;
        check("wr0_wait_cycles", 32'(n), 32'd4);
        check("wr0_idle_req",  32'(bus.mem_req), 32'h0);
        check("wr0_idle_busy", 32'(busy),        32'h0);

        // VIC window offset, then an unmapped offset.
        strobe_wr(13'h1800, 8'hC3);
        check("wr1_addr", 32'(bus.mem_addr), 32'h409800);
        check("wr1_dout", 32'(bus.mem_dout), 32'hC3);
        pulse_ack(8'h00);
        strobe_wr(13'h1000, 8'h11);
        check("wr2_req",  32'(bus.mem_req),    32'h0);
        check("wr2_wait", 32'(bus.ioctl_wait), 32'h0);
        tick();
        check("wr2_wait_late", 32'(bus.ioctl_wait), 32'h0);
        check("wr2_addr_kept", 32'(bus.mem_addr),   32'h409800);

        // Mapped save at the top of the image.
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b1;
        tick();
        strobe_rd(13'h1FFF);
        check("rd0_req",  32'(bus.mem_req),  32'h1);
        check("rd0_we",   32'(bus.mem_we),   32'h0);
        check("rd0_addr", 32'(bus.mem_addr), 32'h409FFF);
        pulse_ack(8'h77);
        check("rd0_dout",      32'(bus.ioctl_dout), 32'h77);
        check("rd0_hold_wait", 32'(bus.ioctl_wait), 32'h1);
        check("rd0_hold_req",  32'(bus.mem_req),    32'h0);
        tick();
        check("rd0_idle_wait", 32'(bus.ioctl_wait), 32'h0);

        // Save with no ack: request withdrawn after TIMEOUT cycles.
        strobe_rd(13'h0800);
        n = 0;
        for (int i = 0; i < 400 && bus.mem_req; i++) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n),              32'd255);
        check("to_err",        32'(error),          32'h1);
        check("to_busy",       32'(busy),           32'h0);
        check("to_dout_kept",  32'(bus.ioctl_dout), 32'h77);
        bus.ioctl_upload = 1'b0;
        tick();
        check("to_err_sticky", 32'(error), 32'h1);
        bus.ioctl_upload = 1'b1;
        tick();
        check("to_err_clear", 32'(error), 32'h0);

        // Unmapped save byte reads back as 0xFF without touching SDRAM.
        strobe_rd(13'h0010);
        check("rd1_dout", 32'(bus.ioctl_dout), 32'hFF);
        check("rd1_req",  32'(bus.mem_req),    32'h0);
        check("rd1_wait", 32'(bus.ioctl_wait), 32'h0);

        // Both flags high with both strobes: only the write happens.
        bus.ioctl_download = 1'b1;
        bus.ioctl_addr     = 13'h0500;
        bus.ioctl_din      = 8'h3C;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_rd       = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        bus.ioctl_rd = 1'b0;
        check("both_we",   32'(bus.mem_we),   32'h1);
        check("both_addr", 32'(bus.mem_addr), 32'h400500);
        check("both_dout", 32'(bus.mem_dout), 32'h3C);
        pulse_ack(8'h99);
        check("both_idout", 32'(bus.ioctl_dout), 32'hFF);
        check("both_busy",  32'(busy),           32'h0);

        // Reset mid-write, then a stray ack two cycles later.
        bus.ioctl_upload = 1'b0;
        strobe_wr(13'h0400, 8'hAA);
        check("rstw_req", 32'(bus.mem_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("rstw");
        tick();
        pulse_ack(8'h55);
        check_reset_values("rstw_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
